// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier (MULT/MULTU) for the EX-stage multi-cycle handshake.
// One partial-product step per cycle; the low half of the product shifts into the multiplier register.
module mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 mul_valid,
    input  logic                 mul_signed,
    output logic                 mul_stall,
    output logic [2*WIDTH-1:0]   mul_result,
    output logic                 mul_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P    = (2*WIDTH)'(1);
    localparam logic [CNT_W-1:0]   ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH-1);

    // |v| for two's-complement inputs; -2^(WIDTH-1) maps onto itself as an unsigned value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? ((~v) + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic neg);
        return neg ? ((~p) + ONE_P) : p;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplr_q   <= mplr_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplr_d   = mplr_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        sum      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_valid) begin
                        mcand_d = magnitude(a, mul_signed);
                        mplr_d  = magnitude(b, mul_signed);
                        neg_d   = mul_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    // Shift {carry, acc, multiplier} right by one.
                    acc_d  = sum[WIDTH:1];
                    mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + ONE_C;
                    if (cnt_q == LAST_CNT) begin
                        result_d = apply_sign({sum[WIDTH:1], sum[0], mplr_q[WIDTH-1:1]}, neg_q);
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    // Pipeline advances here, so a still-high mul_valid must not restart.
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mul_stall  = ~rst & ~flush & (((state_q == IDLE) & mul_valid) | (state_q == BUSY));
    assign mul_done   = (state_q == DONE);
    assign mul_result = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: unsigned/signed products, flush, back-to-back and async reset.
module tb_mul_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] a, b;
    logic        mul_valid, mul_signed;
    logic        mul_stall;
    logic [63:0] mul_result;
    logic        mul_done;

    int compared   = 0;
    int mismatched = 0;

    mul_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .mul_valid  (mul_valid),
        .mul_signed (mul_signed),
        .mul_stall  (mul_stall),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; applies a request and follows it to the done pulse.
    // Leaves mul_valid high through the done cycle; returns at the done cycle's negedge.
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sgn, input logic [63:0] exp);
        int  stalls = 0;
        int  cyc    = 0;
        bit  got    = 0;
        a = av; b = bv; mul_signed = sgn; mul_valid = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (mul_done) begin
                got = 1;
                check({tag, " stall_in_done"}, {63'd0, mul_stall}, 64'd0);
                check({tag, " result"}, mul_result, exp);
            end else begin
                if (mul_stall) stalls++;
                @(posedge clk); #1;
                cyc++;
                a = $urandom; b = $urandom; mul_signed = ~sgn;
            end
        end
        check({tag, " done_seen"}, {63'd0, got}, 64'd1);
        check({tag, " stall_cycles"}, 64'(stalls), 64'd33);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mul_done) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; a = '0; b = '0; mul_valid = 1'b0; mul_signed = 1'b0;
        #2;
        check("reset stall", {63'd0, mul_stall}, 64'd0);
        check("reset done", {63'd0, mul_done}, 64'd0);
        check("reset result", mul_result, 64'd0);
        mul_valid = 1'b1;
        #1;
        check("reset stall_with_valid", {63'd0, mul_stall}, 64'd0);
        mul_valid = 1'b0;
        #9 rst = 1'b0;

        @(posedge clk); #1;
        run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(negedge clk);
        check("idle stall", {63'd0, mul_stall}, 64'd0);

        @(posedge clk); #1;
        run_op("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("s_m3xm7", 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 64'h0000_0000_0000_0015);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("u_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("u_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("s_0xm5", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0);
        @(posedge clk); #1; mul_valid = 1'b0;
        @(posedge clk); #1;
        run_op("s_m1x1", 32'hFFFF_FFFF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1; mul_valid = 1'b0;

        // Flush ten cycles into BUSY; previous result must survive.
        @(posedge clk); #1;
        a = 32'd5; b = 32'd6; mul_signed = 1'b0; mul_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check("flush stall_same_cycle", {63'd0, mul_stall}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; mul_valid = 1'b0;
        @(negedge clk);
        check("flush stall_after", {63'd0, mul_stall}, 64'd0);
        count_done("flush no_done", 40);
        check("flush result_kept", mul_result, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        run_op("after_flush_3x4", 32'd3, 32'd4, 1'b0, 64'd12);
        @(posedge clk); #1; mul_valid = 1'b0;

        // Request coinciding with flush is dropped.
        @(posedge clk); #1;
        a = 32'd9; b = 32'd9; mul_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_req stall", {63'd0, mul_stall}, 64'd0);
        @(posedge clk); #1; flush = 1'b0; mul_valid = 1'b0;
        count_done("flush_req no_done", 40);
        check("flush_req result_kept", mul_result, 64'd12);

        // Back-to-back: valid held through DONE, second op presented next cycle.
        @(posedge clk); #1;
        run_op("b2b_first", 32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);
        @(posedge clk); #1;
        run_op("b2b_second", 32'd100, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C);
        @(posedge clk); #1; mul_valid = 1'b0;

        // Asynchronous reset pulse between edges while BUSY.
        @(posedge clk); #1;
        a = 32'd11; b = 32'd13; mul_signed = 1'b0; mul_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("areset stall", {63'd0, mul_stall}, 64'd0);
        check("areset done", {63'd0, mul_done}, 64'd0);
        check("areset result", mul_result, 64'd0);
        mul_valid = 1'b0;
        #1 rst = 1'b0;
        count_done("areset no_done", 40);
        @(posedge clk); #1;
        run_op("after_reset_6x7", 32'd6, 32'd7, 1'b0, 64'd42);
        @(posedge clk); #1; mul_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Iterative radix-2 shift-add multiplier.
- It is the responder side of the EX-stage multi-cycle arithmetic handshake: the ALU raises a request, holds operands, and consumes the stall and 64-bit result for the HI/LO write.
- Supports signed (MULT) and unsigned (MULTU) operation. It uses the same valid/signed/flush/stall/result contract as the divider, so the hazard unit treats both units identically.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  EX-stage flush; abandons any operation in progress.
- a  input  WIDTH  multiplicand (rs).
- b  input  WIDTH  multiplier (rt).
- mul_valid  input  1  request; held high by the ALU while a MULT/MULTU is in EX.
- mul_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- mul_stall  output  1  pipeline stall request.
- mul_result  output  2*WIDTH  product as {HI, LO}.
- mul_done  output  1  one-cycle pulse; mul_result is valid this cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; counter = 0; accumulator, operand registers and mul_result = 0; mul_done = 0.
  - mul_stall = 0 while rst is high.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mul_valid & ~flush: latch |a| and |b| (magnitudes when mul_signed=1, raw operands otherwise).
  - Latch neg = mul_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear accumulator, set counter = 0, go to BUSY.
  - Otherwise remain in IDLE.
- BUSY, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator with WIDTH+1-bit carry.
  - Shift {carry, acc, multiplier} right by 1; increment counter.
  - When counter reaches WIDTH-1 on this cycle's iteration (i.e. after WIDTH iterations): write mul_result = neg ? -product : product, then go to DONE.
- DONE:
  - mul_done = 1 for exactly this cycle; mul_stall = 0.
  - Next state is IDLE unconditionally, even if mul_valid is still high. This cycle is where the pipeline advances, so no restart occurs.
- mul_stall is combinational:
  - mul_stall = ~flush & ((state==IDLE & mul_valid) | state==BUSY).
  - It is 0 in DONE.
- Latency: request seen in cycle 0; mul_stall high cycles 0..WIDTH (33 cycles for WIDTH=32); mul_done and result in cycle WIDTH+1.
- mul_result holds its value until the next completed operation. It is not cleared on flush or on return to IDLE.
- Flush:
  - flush=1 in any state forces next state IDLE and clears counter.
  - mul_result is not updated and mul_done is not asserted.
  - flush in the same cycle as a new request: the request is ignored.
- Operand stability: a and b are sampled only at the IDLE→BUSY transition. Changes during BUSY have no effect.
- Signed edge cases:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as an unsigned WIDTH-bit value; no overflow.
  - (-2^31)*(-2^31) = 2^62.
  - Any operand 0 gives 0 regardless of neg; negating 0 yields 0.
- Arithmetic is exact over 2*WIDTH bits; there is no overflow or exception output.
- mul_signed is ignored outside the IDLE accept cycle.

Test Plan:
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, mul_signed=0 → mul_stall high 33 cycles, then mul_done=1 with mul_result=0xFFFFFFFE_00000001.
- Signed mixed: a=0xFFFFFFFD (-3), b=7, mul_signed=1 → mul_result=0xFFFFFFFF_FFFFFFEB (-21). a=-3, b=-7 → 0x00000000_00000015.
- Signed extreme: a=b=0x80000000, mul_signed=1 → mul_result=0x40000000_00000000. Same operands with mul_signed=0 → also 0x40000000_00000000.
- Flush: start 5*6, assert flush at cycle 10 of BUSY →
  - mul_stall drops the same cycle; state IDLE next cycle.
  - mul_done never pulses; mul_result keeps its previous value.
  - A new request 3*4 then completes with 12.
- Back-to-back: hold mul_valid high across DONE with new operands next cycle →
  - no restart in the DONE cycle;
  - second operation starts the following IDLE cycle with its own 33-cycle stall.
- Async reset mid-BUSY: pulse rst between clock edges → immediately mul_stall=0, mul_done=0, mul_result=0; state IDLE after release.
